// File: rtl/regfile_param.sv
`timescale 1ns/1ps
// Parametrised register file: two combinational read ports, one write port, bulk-clear engine.
// Reads are zero-latency; a clear takes DEPTH cycles with busy high, and writes/clears are dropped meanwhile.
module regfile_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeRegister,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readRegister1,
    input  logic [ADDR_W-1:0] readRegister2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    input  logic              clear,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic zero_target;
    logic write_ok;
    logic write_now;
    logic bypass_en;
    logic last_entry;

    // Entry 0 is read-only when it is hard-wired to zero.
    assign zero_target = (ZERO_REG != 0) && (writeRegister == '0);
    assign write_ok    = regWrite && !zero_target;
    assign write_now   = (state == ST_IDLE) && !clear && write_ok;
    assign bypass_en   = (BYPASS != 0) && write_now;
    assign last_entry  = (ptr == ADDR_W'(DEPTH - 1));

    assign busy = (state == ST_CLEAR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        state <= ST_CLEAR;
                        ptr   <= '0;
                    end else if (write_ok) begin
                        mem[writeRegister] <= writeData;
                    end
                end
                ST_CLEAR: begin
                    mem[ptr] <= '0;
                    if (last_entry) begin
                        state <= ST_IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    // Zero register overrides bypass, bypass overrides stored contents.
    always_comb begin
        readData1 = mem[readRegister1];
        if (bypass_en && (readRegister1 == writeRegister)) begin
            readData1 = writeData;
        end
        if ((ZERO_REG != 0) && (readRegister1 == '0)) begin
            readData1 = '0;
        end
    end

    always_comb begin
        readData2 = mem[readRegister2];
        if (bypass_en && (readRegister2 == writeRegister)) begin
            readData2 = writeData;
        end
        if ((ZERO_REG != 0) && (readRegister2 == '0)) begin
            readData2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
`timescale 1ns/1ps
// Bench for regfile_param: a default 8x8 instance and a 16x16 zero-register/no-bypass instance.
module tb_regfile_param;

    logic clock;
    logic reset_n;

    logic       r0_we, r0_clr, r0_busy;
    logic [2:0] r0_wa, r0_ra1, r0_ra2;
    logic [7:0] r0_wd, r0_rd1, r0_rd2;

    logic        r1_we, r1_clr, r1_busy;
    logic [3:0]  r1_wa, r1_ra1, r1_ra2;
    logic [15:0] r1_wd, r1_rd1, r1_rd2;

    int vec;
    int miscmp;

    // Reference model: contents per instance and remaining clear cycles.
    logic [15:0] mm [2][16];
    int          cnt [2];

    regfile_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut0 (
        .clock(clock), .reset_n(reset_n), .regWrite(r0_we), .writeRegister(r0_wa),
        .writeData(r0_wd), .readRegister1(r0_ra1), .readRegister2(r0_ra2),
        .readData1(r0_rd1), .readData2(r0_rd2), .clear(r0_clr), .busy(r0_busy)
    );

    regfile_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) dut1 (
        .clock(clock), .reset_n(reset_n), .regWrite(r1_we), .writeRegister(r1_wa),
        .writeData(r1_wd), .readRegister1(r1_ra1), .readRegister2(r1_ra2),
        .readData1(r1_rd1), .readData2(r1_rd2), .clear(r1_clr), .busy(r1_busy)
    );

    initial clock = 1'b0;
    always #50 clock = ~clock;

    function automatic int depth_of(int k);
        return (k == 0) ? 8 : 16;
    endfunction

    function automatic logic [15:0] exp_rd(int k, int a, bit we, int wa, logic [15:0] wd, bit clr);
        bit z;
        bit b;
        z = (k == 1);
        b = (k == 0);
        if (z && a == 0) return 16'h0;
        if (b && cnt[k] == 0 && !clr && we && a == wa && !(z && wa == 0)) return wd;
        return mm[k][a];
    endfunction

    function automatic void model_step(int k, bit we, int wa, logic [15:0] wd, bit clr);
        bit z;
        z = (k == 1);
        if (cnt[k] > 0) begin
            mm[k][depth_of(k) - cnt[k]] = 16'h0;
            cnt[k]--;
        end else if (clr) begin
            cnt[k] = depth_of(k);
        end else if (we && !(z && wa == 0)) begin
            mm[k][wa] = wd;
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0;
            for (int a = 0; a < 16; a++) mm[k][a] = 16'h0;
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step(0, r0_we, int'(r0_wa), {8'h00, r0_wd}, r0_clr);
        model_step(1, r1_we, int'(r1_wa), r1_wd, r1_clr);
        #1;
    endtask

    task automatic idle_inputs();
        r0_we = 0; r0_clr = 0; r0_wa = 0; r0_wd = 0;
        r1_we = 0; r1_clr = 0; r1_wa = 0; r1_wd = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        r0_ra1 = 3'd5; r0_ra2 = 3'd2; r1_ra1 = 4'd9; r1_ra2 = 4'd1;
        model_reset();
        #20;
        vec++;
        if (r0_busy !== 1'b0 || r1_busy !== 1'b0) begin
            miscmp++; $display("FAIL reset_busy: got %b/%b want 0/0", r0_busy, r1_busy);
        end
        vec++;
        if (r0_rd1 !== 8'h00 || r1_rd1 !== 16'h0000) begin
            miscmp++; $display("FAIL reset_read: got %h/%h want 00/0000", r0_rd1, r1_rd1);
        end
        #10 reset_n = 1;
        @(posedge clock); #1;
        for (int i = 1; i < 8; i++) begin
            r0_we = 1; r0_wa = 3'(i); r0_wd = 8'(i * 8'h11);
            tick();
        end
        r0_we = 0;
        r0_ra1 = 3'd7; #1;
        vec++;
        if (r0_rd1 !== 8'h77) begin
            miscmp++; $display("FAIL prefill_e7: got %h want 77", r0_rd1);
        end
        reset_n = 0;
        model_reset();
        #2;
        for (int a = 0; a < 8; a++) begin
            r0_ra1 = 3'(a); r0_ra2 = 3'(7 - a); #1;
            vec++;
            if (r0_rd1 !== 8'h00 || r0_rd2 !== 8'h00 || r0_busy !== 1'b0) begin
                miscmp++; $display("FAIL reset_async a=%0d: got %h/%h busy %b want 00/00 busy 0", a, r0_rd1, r0_rd2, r0_busy);
            end
        end
        reset_n = 1;
    endtask

    task automatic test_write_bypass();
        r0_we = 1; r0_wa = 3'd3; r0_wd = 8'hA5; r0_ra1 = 3'd3;
        r1_we = 1; r1_wa = 4'd3; r1_wd = 16'h00A5; r1_ra1 = 4'd3;
        #1;
        vec++;
        if (r0_rd1 !== 8'hA5) begin
            miscmp++; $display("FAIL bypass_pre: got %h want a5", r0_rd1);
        end
        vec++;
        if (r1_rd1 !== 16'h0000) begin
            miscmp++; $display("FAIL nobypass_pre: got %h want 0000", r1_rd1);
        end
        tick();
        r0_we = 0; r1_we = 0; #1;
        vec++;
        if (r0_rd1 !== 8'hA5) begin
            miscmp++; $display("FAIL write_post: got %h want a5", r0_rd1);
        end
        vec++;
        if (r1_rd1 !== 16'h00A5) begin
            miscmp++; $display("FAIL nobypass_post: got %h want 00a5", r1_rd1);
        end
    endtask

    task automatic test_zero_reg();
        r1_we = 1; r1_wa = 4'd0; r1_wd = 16'hFFFF; r1_ra1 = 4'd0; r1_ra2 = 4'd0;
        r0_we = 1; r0_wa = 3'd0; r0_wd = 8'hFF; r0_ra1 = 3'd0; r0_ra2 = 3'd0;
        #1;
        vec++;
        if (r1_rd1 !== 16'h0 || r1_rd2 !== 16'h0) begin
            miscmp++; $display("FAIL zero_pre: got %h/%h want 0000/0000", r1_rd1, r1_rd2);
        end
        vec++;
        if (r0_rd1 !== 8'hFF || r0_rd2 !== 8'hFF) begin
            miscmp++; $display("FAIL e0_bypass: got %h/%h want ff/ff", r0_rd1, r0_rd2);
        end
        tick();
        r0_we = 0; r1_we = 0; #1;
        vec++;
        if (r1_rd1 !== 16'h0 || r1_rd2 !== 16'h0) begin
            miscmp++; $display("FAIL zero_post: got %h/%h want 0000/0000", r1_rd1, r1_rd2);
        end
        vec++;
        if (r0_rd1 !== 8'hFF) begin
            miscmp++; $display("FAIL e0_stored: got %h want ff", r0_rd1);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 8; i++) begin
            r0_we = 1; r0_wa = 3'(i); r0_wd = 8'hC3;
            tick();
        end
        r0_clr = 1; r0_we = 1; r0_wa = 3'd5; r0_wd = 8'h5A; r0_ra1 = 3'd5; #1;
        vec++;
        if (r0_rd1 !== 8'hC3 || r0_busy !== 1'b0) begin
            miscmp++; $display("FAIL clear_req_read: got %h busy %b want c3 busy 0", r0_rd1, r0_busy);
        end
        tick();
        r0_clr = 0;
        for (int c = 0; c < 8; c++) begin
            r0_we = 1; r0_wa = 3'($urandom_range(0, 7)); r0_wd = 8'($urandom);
            r0_clr = (c == 4);
            #1;
            vec++;
            if (r0_busy !== 1'b1) begin
                miscmp++; $display("FAIL clear_busy c=%0d: got %b want 1", c, r0_busy);
            end
            if (c == 3) begin
                for (int a = 0; a < 8; a++) begin
                    r0_ra1 = 3'(a); r0_ra2 = 3'(a); #1;
                    vec++;
                    if (r0_rd1 !== ((a < 3) ? 8'h00 : 8'hC3) || r0_rd2 !== r0_rd1) begin
                        miscmp++; $display("FAIL clear_partial a=%0d: got %h/%h want %h", a, r0_rd1, r0_rd2, (a < 3) ? 8'h00 : 8'hC3);
                    end
                end
            end
            tick();
        end
        r0_we = 0; r0_clr = 0; #1;
        vec++;
        if (r0_busy !== 1'b0) begin
            miscmp++; $display("FAIL clear_end_busy: got %b want 0", r0_busy);
        end
        for (int a = 0; a < 8; a++) begin
            r0_ra1 = 3'(a); #1;
            vec++;
            if (r0_rd1 !== 8'h00) begin
                miscmp++; $display("FAIL clear_done a=%0d: got %h want 00", a, r0_rd1);
            end
        end
        r0_we = 1; r0_wa = 3'd2; r0_wd = 8'h99;
        tick();
        r0_we = 0; r0_ra1 = 3'd2; #1;
        vec++;
        if (r0_rd1 !== 8'h99) begin
            miscmp++; $display("FAIL write_after_clear: got %h want 99", r0_rd1);
        end
    endtask

    task automatic test_reset_midclear();
        r0_we = 1; r0_wa = 3'd6; r0_wd = 8'h66;
        tick();
        r0_we = 0; r0_clr = 1;
        tick();
        r0_clr = 0;
        for (int i = 0; i < 4; i++) tick();
        vec++;
        if (r0_busy !== 1'b1) begin
            miscmp++; $display("FAIL midclear_busy: got %b want 1", r0_busy);
        end
        reset_n = 0;
        model_reset();
        #2;
        vec++;
        if (r0_busy !== 1'b0) begin
            miscmp++; $display("FAIL midclear_reset_busy: got %b want 0", r0_busy);
        end
        for (int a = 0; a < 8; a++) begin
            r0_ra1 = 3'(a); #1;
            vec++;
            if (r0_rd1 !== 8'h00) begin
                miscmp++; $display("FAIL midclear_reset a=%0d: got %h want 00", a, r0_rd1);
            end
        end
        reset_n = 1;
        r0_we = 1; r0_wa = 3'd6; r0_wd = 8'h42;
        tick();
        r0_we = 0; r0_ra1 = 3'd6; #1;
        vec++;
        if (r0_rd1 !== 8'h42 || r0_busy !== 1'b0) begin
            miscmp++; $display("FAIL midclear_write: got %h busy %b want 42 busy 0", r0_rd1, r0_busy);
        end
    endtask

    task automatic test_param_sweep();
        int n;
        r1_we = 1; r1_wa = 4'd15; r1_wd = 16'hBEEF;
        tick();
        r1_we = 0; r1_ra1 = 4'd15; r1_ra2 = 4'd15; #1;
        vec++;
        if (r1_rd1 !== 16'hBEEF || r1_rd2 !== 16'hBEEF) begin
            miscmp++; $display("FAIL wide_read: got %h/%h want beef/beef", r1_rd1, r1_rd2);
        end
        r1_clr = 1;
        tick();
        r1_clr = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!r1_busy) break;
            n++;
            tick();
        end
        vec++;
        if (n != 16) begin
            miscmp++; $display("FAIL wide_busy_len: got %0d want 16", n);
        end
        vec++;
        if (r1_rd1 !== 16'h0) begin
            miscmp++; $display("FAIL wide_cleared: got %h want 0000", r1_rd1);
        end
    endtask

    task automatic test_random();
        logic [15:0] e;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r0_we = 1'($urandom); r0_wa = 3'($urandom); r0_wd = 8'($urandom);
            r0_clr = ($urandom_range(0, 24) == 0);
            r1_we = 1'($urandom); r1_wa = 4'($urandom); r1_wd = 16'($urandom);
            r1_clr = ($urandom_range(0, 30) == 0);
            if ($urandom_range(0, 99) == 0) begin
                reset_n = 0;
                model_reset();
                #1 reset_n = 1;
            end
            for (int j = 0; j < 2; j++) begin
                r0_ra1 = (j == 0) ? r0_wa : 3'($urandom);
                r0_ra2 = 3'($urandom);
                r1_ra1 = (j == 0) ? r1_wa : 4'($urandom);
                r1_ra2 = 4'($urandom);
                #1;
                e = exp_rd(0, int'(r0_ra1), r0_we, int'(r0_wa), {8'h00, r0_wd}, r0_clr);
                vec++;
                if (r0_rd1 !== 8'(e)) begin
                    miscmp++; $display("FAIL rnd0_rd1 cyc=%0d a=%0d: got %h want %h", cyc, r0_ra1, r0_rd1, 8'(e));
                end
                e = exp_rd(0, int'(r0_ra2), r0_we, int'(r0_wa), {8'h00, r0_wd}, r0_clr);
                vec++;
                if (r0_rd2 !== 8'(e)) begin
                    miscmp++; $display("FAIL rnd0_rd2 cyc=%0d a=%0d: got %h want %h", cyc, r0_ra2, r0_rd2, 8'(e));
                end
                e = exp_rd(1, int'(r1_ra1), r1_we, int'(r1_wa), r1_wd, r1_clr);
                vec++;
                if (r1_rd1 !== e) begin
                    miscmp++; $display("FAIL rnd1_rd1 cyc=%0d a=%0d: got %h want %h", cyc, r1_ra1, r1_rd1, e);
                end
                e = exp_rd(1, int'(r1_ra2), r1_we, int'(r1_wa), r1_wd, r1_clr);
                vec++;
                if (r1_rd2 !== e) begin
                    miscmp++; $display("FAIL rnd1_rd2 cyc=%0d a=%0d: got %h want %h", cyc, r1_ra2, r1_rd2, e);
                end
            end
            vec++;
            if (r0_busy !== (cnt[0] != 0) || r1_busy !== (cnt[1] != 0)) begin
                miscmp++; $display("FAIL rnd_busy cyc=%0d: got %b/%b want %b/%b", cyc, r0_busy, r1_busy, cnt[0] != 0, cnt[1] != 0);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        vec = 0;
        miscmp = 0;
        test_reset();
        test_write_bypass();
        test_zero_reg();
        test_clear();
        test_reset_midclear();
        test_param_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file for the datapath, replacing the fixed 8×8 two-read/one-write file. Adds width/depth parameters, an optional hard-wired zero register, optional write-to-read bypass, asynchronous reset of all entries, and a sequenced bulk-clear engine with a busy flag. It sits between decode (read addresses), the ALU operand muxes (read data) and writeback (write port).

## Interface
Parameters:
- DATA_W, 8, data width in bits (≥1)
- ADDR_W, 3, address width; DEPTH = 2^ADDR_W entries
- ZERO_REG, 0, 1: entry 0 always reads 0 and ignores writes
- BYPASS, 1, 1: a read of the address being written this cycle returns writeData

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- regWrite  in  1  write enable
- writeRegister  in  ADDR_W  write address
- writeData  in  DATA_W  write data
- readRegister1  in  ADDR_W  read address, port 1
- readRegister2  in  ADDR_W  read address, port 2
- readData1  out  DATA_W  read data, port 1 (combinational)
- readData2  out  DATA_W  read data, port 2 (combinational)
- clear  in  1  request bulk clear (sampled at rising edge)
- busy  out  1  high while the clear sequence runs

## Operation
- Storage: DEPTH × DATA_W registers; clear pointer ptr (ADDR_W bits); FSM states IDLE, CLEAR.
- Reset (reset_n=0, immediate, no clock needed): all entries 0, state IDLE, ptr 0, busy 0. Consequently readData1/2 = 0.
- IDLE:
  - clear=1 at edge → state CLEAR, ptr=0. regWrite in the same cycle is dropped (clear wins).
  - clear=0, regWrite=1 → entry[writeRegister] ← writeData, except address 0 when ZERO_REG=1.
- CLEAR: each edge writes 0 to entry[ptr]. If ptr==DEPTH-1 → IDLE, ptr=0; else ptr+1.
  - regWrite is ignored; clear is ignored (no restart, no queuing).
- busy = (state==CLEAR), registered.
- Reads, per port independently:
  - ZERO_REG=1 and address 0 → 0.
  - Else if BYPASS=1, state IDLE, clear=0, regWrite=1, and address == writeRegister → writeData (and not address 0 under ZERO_REG).
  - Else stored entry. Reads during CLEAR return stored contents (cleared entries read 0, uncleared entries hold old values).
- Both ports may read the same address; no arbitration.
- Widths exact; no truncation or extension anywhere.

## Timing
- Write latency: data written at edge N is visible from stored contents immediately after edge N; with BYPASS=1 it is also visible combinationally during the cycle before edge N.
- Read latency: zero cycles (combinational from address/state).
- Clear: clear=1 sampled at edge K → busy=1 from just after K through edge K+DEPTH; busy=0 after edge K+DEPTH. Entry i is zero after edge K+1+i; all entries zero after K+DEPTH. Total clear time = DEPTH cycles.
- First regWrite accepted at edge K+DEPTH+1 (first edge with busy=0 beforehand).
- reset_n asserted mid-clear: immediate IDLE, busy 0, all entries 0; deasserting does not resume the clear.
- reset_n deassertion is presumed synchronised upstream; no edge may coincide with deassertion.

## Test plan
- Reset: write entries 1..7 with 0x11..0x77, pulse reset_n low between edges → all reads 0x00 immediately, busy=0.
- Write/read + bypass (defaults): regWrite=1, writeRegister=3, writeData=0xA5, readRegister1=3 → readData1=0xA5 before the edge; after the edge with regWrite=0 → still 0xA5. Repeat with BYPASS=0 → 0x00 before the edge, 0xA5 after.
- ZERO_REG=1: write 0xFF to entry 0 → readData1/2 at address 0 = 0x00 before and after the edge, including the bypass path.
- Bulk clear: fill all 8 entries with 0xC3, assert clear one cycle with regWrite=1 to entry 5 → write dropped; busy high for exactly 8 cycles; after 3 cycles entries 0–2 read 0x00, entries 3–7 read 0xC3; regWrite during busy has no effect; clear during busy does not extend it.
- Reset mid-clear: start clear, assert reset_n after 4 cycles → busy=0 at once, all 0; a write on the next edge succeeds.
- Parameter sweep: DATA_W=16, ADDR_W=4 → busy lasts 16 cycles; 0xBEEF written to entry 15 is read back exactly on both ports.
